// File: rtl/alu_div_pkg.sv
// Shared types for the alu_div sequential divider.
// div_op_e selects unsigned (DIVU) or signed (DIV) division.
// div_state_e is the divider control state.
package alu_div_pkg;

    typedef enum logic [0:0] {
        DIV_OP_DIVU = 1'b0,
        DIV_OP_DIV  = 1'b1
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ITERATE = 3'd2,
        FIXUP   = 3'd3,
        DONE    = 3'd4
    } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step (combinational).
// Ports:
//   i_rem      : partial remainder, DATA_W+1 bits (always < divisor)
//   i_bit      : next dividend bit shifted into the remainder
//   i_divisor  : divisor magnitude
//   o_rem_c    : new partial remainder
//   o_qbit_c   : quotient bit produced by this step
module div_step #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W:0]   i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W:0]   o_rem_c,
    output logic              o_qbit_c
);

    localparam int unsigned RW = DATA_W + 1;

    logic [RW:0] w_shift;
    logic [RW:0] w_dvs;

    // One extra bit of headroom so the compare never wraps.
    assign w_shift  = {i_rem, i_bit};
    assign w_dvs    = {2'b00, i_divisor};
    assign o_qbit_c = (w_shift >= w_dvs);
    assign o_rem_c  = o_qbit_c ? RW'(w_shift - w_dvs) : RW'(w_shift);

endmodule

// File: rtl/alu_div.sv
// Sequential restoring divider: 2n-bit dividend / n-bit divisor,
// n = DATA_W (wide=1) or DATA_W/2 (byte mode), signed or unsigned.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : request a division (accepted only in IDLE)
//   op, wide          : operation type and width select
//   dividend, divisor : operands (byte mode uses low 2n / n bits)
//   busy, done        : busy while not IDLE; done pulses one cycle
//   quotient, remainder, div_error : results, held until next start
module alu_div
    import alu_div_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  div_op_e               op,
    input  logic                  wide,
    input  logic [2*DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]     divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     quotient,
    output logic [DATA_W-1:0]     remainder,
    output logic                  div_error
);

    localparam int unsigned DW2   = 2 * DATA_W;
    localparam int unsigned HW    = DATA_W / 2;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    div_state_e r_state;
    div_state_e w_next;

    // Latched request
    div_op_e           r_op;
    logic              r_wide;
    logic [DW2-1:0]    r_dvd_in;
    logic [DATA_W-1:0] r_dvs_in;

    // Working datapath
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_ovf;
    logic [DATA_W:0]   r_prem;
    logic [DATA_W-1:0] r_dlo;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_dvs;
    logic [CNT_W-1:0]  r_cnt;

    // Registered outputs
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic              r_err;

    logic              w_signed;
    logic [DW2-1:0]    w_dvd_mask;
    logic [DATA_W-1:0] w_n_mask;
    logic [DW2-1:0]    w_dvd_m;
    logic [DATA_W-1:0] w_dvs_m;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DW2-1:0]    w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo_al;
    logic              w_hi_ovf;
    logic              w_setup_err;
    logic [CNT_W-1:0]  w_n;

    logic [DATA_W:0]   w_step_rem;
    logic              w_step_q;

    logic              w_q_neg;
    logic [DATA_W-1:0] w_lim;
    logic              w_fix_err;
    logic [DATA_W-1:0] w_fix_q;
    logic [DATA_W-1:0] w_fix_r;

    // Operand conditioning used in SETUP: masking, sign extraction, magnitudes
    assign w_signed   = (r_op == DIV_OP_DIV);
    assign w_dvd_mask = r_wide ? '1 : {DATA_W'(0), {DATA_W{1'b1}}};
    assign w_n_mask   = r_wide ? '1 : {HW'(0), {HW{1'b1}}};
    assign w_dvd_m    = r_dvd_in & w_dvd_mask;
    assign w_dvs_m    = r_dvs_in & w_n_mask;
    assign w_dvd_neg  = r_wide ? r_dvd_in[DW2-1] : r_dvd_in[DATA_W-1];
    assign w_dvs_neg  = r_wide ? r_dvs_in[DATA_W-1] : r_dvs_in[HW-1];
    assign w_dvd_mag  = (w_signed && w_dvd_neg) ? ((DW2'(0) - w_dvd_m) & w_dvd_mask) : w_dvd_m;
    assign w_dvs_mag  = (w_signed && w_dvs_neg) ? ((DATA_W'(0) - w_dvs_m) & w_n_mask) : w_dvs_m;

    // High half seeds the partial remainder; low half is left-aligned so the
    // next dividend bit is always the MSB of r_dlo.
    assign w_hi    = r_wide ? w_dvd_mag[DW2-1:DATA_W] : {HW'(0), w_dvd_mag[DATA_W-1:HW]};
    assign w_lo_al = r_wide ? w_dvd_mag[DATA_W-1:0] : {w_dvd_mag[HW-1:0], HW'(0)};

    // high half >= divisor means the quotient cannot fit in n bits
    assign w_hi_ovf    = (w_hi >= w_dvs_mag);
    assign w_setup_err = (w_dvs_m == '0) || (!w_signed && w_hi_ovf);
    assign w_n         = r_wide ? CNT_W'(DATA_W) : CNT_W'(HW);

    div_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .i_rem     (r_prem),
        .i_bit     (r_dlo[DATA_W-1]),
        .i_divisor (r_dvs),
        .o_rem_c   (w_step_rem),
        .o_qbit_c  (w_step_q)
    );

    // Sign restore and signed range check; w_lim = 2^(n-1)
    assign w_q_neg   = w_signed && r_sign_q;
    assign w_lim     = r_wide ? (DATA_W'(1) << (DATA_W - 1)) : (DATA_W'(1) << (HW - 1));
    assign w_fix_err = w_signed && (r_ovf || (w_q_neg ? (r_q > w_lim) : (r_q >= w_lim)));
    assign w_fix_q   = w_q_neg ? ((DATA_W'(0) - r_q) & w_n_mask) : r_q;
    assign w_fix_r   = (w_signed && r_sign_r) ?
                       ((DATA_W'(0) - r_prem[DATA_W-1:0]) & w_n_mask) : r_prem[DATA_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETUP;
            SETUP:   w_next = w_setup_err ? DONE : ITERATE;
            ITERATE: if (r_cnt == CNT_W'(1)) w_next = FIXUP;
            FIXUP:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= DIV_OP_DIVU;
            r_wide   <= 1'b0;
            r_dvd_in <= '0;
            r_dvs_in <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_ovf    <= 1'b0;
            r_prem   <= '0;
            r_dlo    <= '0;
            r_q      <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_wide   <= wide;
                        r_dvd_in <= dividend;
                        r_dvs_in <= divisor;
                        r_quot   <= '0;
                        r_rem    <= '0;
                        r_err    <= 1'b0;
                    end
                end
                SETUP: begin
                    r_sign_q <= w_signed && (w_dvd_neg ^ w_dvs_neg);
                    r_sign_r <= w_signed && w_dvd_neg;
                    r_ovf    <= w_signed && w_hi_ovf;
                    r_prem   <= {1'b0, w_hi};
                    r_dlo    <= w_lo_al;
                    r_dvs    <= w_dvs_mag;
                    r_q      <= '0;
                    r_cnt    <= w_setup_err ? '0 : w_n;
                    if (w_setup_err) begin
                        r_err <= 1'b1;
                    end
                end
                ITERATE: begin
                    r_prem <= w_step_rem;
                    r_dlo  <= r_dlo << 1;
                    r_q    <= {r_q[DATA_W-2:0], w_step_q};
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                FIXUP: begin
                    r_err  <= w_fix_err;
                    r_quot <= w_fix_err ? '0 : w_fix_q;
                    r_rem  <= w_fix_err ? '0 : w_fix_r;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_error = r_err;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div (DATA_W = 16): directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_div;
    import alu_div_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    div_op_e     op;
    logic        wide;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_error;

    int n_checks = 0;
    int n_fail   = 0;

    alu_div #(.DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .wide      (wide),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_error (div_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic void ref_div(input logic op_s, input logic w,
                                    input logic [31:0] dvd_in, input logic [15:0] dvs_in,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic e, output int lat);
        int n;
        longint dvd, dvs, sd, sv, sq, sr, mask;
        n    = w ? 16 : 8;
        mask = (longint'(1) << n) - 1;
        dvd  = longint'(dvd_in) & ((longint'(1) << (2 * n)) - 1);
        dvs  = longint'(dvs_in) & mask;
        q = '0; r = '0; e = 1'b0; lat = n + 3;
        if (dvs == 0) begin
            e = 1'b1; lat = 2;
            return;
        end
        if (!op_s) begin
            if (dvd / dvs > mask) begin
                e = 1'b1; lat = 2;
                return;
            end
            q = 16'(dvd / dvs);
            r = 16'(dvd % dvs);
        end else begin
            sd = dvd;
            if (((dvd >> (2 * n - 1)) & 1) == 1) sd = dvd - (longint'(1) << (2 * n));
            sv = dvs;
            if (((dvs >> (n - 1)) & 1) == 1) sv = dvs - (longint'(1) << n);
            sq = sd / sv;
            sr = sd % sv;
            if (sq > (longint'(1) << (n - 1)) - 1 || sq < -(longint'(1) << (n - 1))) begin
                e = 1'b1;
                return;
            end
            q = 16'(sq & mask);
            r = 16'(sr & mask);
        end
    endfunction

    // Issue one request and check timing, busy, results and the idle return.
    task automatic run_op(input string tag, input logic op_s, input logic w,
                          input logic [31:0] dvd_v, input logic [15:0] dvs_v,
                          input logic [15:0] eq, input logic [15:0] er, input logic ee,
                          input int elat, input bit hold);
        int cyc;
        int busy_bad;
        op       = op_s ? DIV_OP_DIV : DIV_OP_DIVU;
        wide     = w;
        dividend = dvd_v;
        divisor  = dvs_v;
        start    = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        if (!hold) start = 1'b0;
        check({tag, " busy@N+1"}, 32'(busy), 32'd1);
        check({tag, " cleared@N+1"}, {quotient, remainder}, 32'd0);
        // operands must not be re-sampled after acceptance
        dividend = $urandom;
        divisor  = 16'($urandom);
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done_latency"}, 32'(cyc), 32'(elat));
        check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_error"}, 32'(div_error), 32'(ee));
        // With hold, start is still high on the edge that leaves DONE.
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check({tag, " still_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, " held"}, {quotient, remainder}, {eq, er});
        check({tag, " held_err"}, 32'(div_error), 32'(ee));
    endtask

    initial begin
        logic [15:0] eq, er;
        logic        ee;
        int          lat;
        logic        op_s, w;
        logic [31:0] dvd_v;
        logic [15:0] dvs_v;
        longint      n, dvs_m, hi;

        reset = 1'b1; start = 1'b0; op = DIV_OP_DIVU; wide = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {27'd0, busy, done, div_error, 2'b00}, 32'd0);
        check("reset_results", {quotient, remainder}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_op("divu_wide", 1'b0, 1'b1, 32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 19, 1'b0);
        run_op("divu_byte", 1'b0, 1'b0, 32'h0000_00FF, 16'h0010, 16'h000F, 16'h000F, 1'b0, 11, 1'b0);
        run_op("div_byte_neg", 1'b1, 1'b0, 32'h0000_FFF9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 11, 1'b0);
        run_op("div_by_zero", 1'b0, 1'b1, 32'h0000_1234, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
        run_op("divu_byte_ovf", 1'b0, 1'b0, 32'h0000_0200, 16'h0002, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
        run_op("div_byte_ovf", 1'b1, 1'b0, 32'h0000_FF80, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 11, 1'b0);
        run_op("div_wide_neg", 1'b1, 1'b1, 32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 19, 1'b0);
        run_op("hold_start", 1'b0, 1'b1, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 19, 1'b1);

        // Reset in the middle of a wide divide
        op = DIV_OP_DIVU; wide = 1'b1; dividend = 32'h0001_0000; divisor = 16'h0002;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_ctrl", {29'd0, busy, done, div_error}, 32'd0);
        check("midreset_results", {quotient, remainder}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", {30'd0, busy, done}, 32'd0);

        // Reset wins over a simultaneous start
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        check("reset_over_start", 32'(busy), 32'd0);
        run_op("after_reset", 1'b0, 1'b1, 32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 19, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op_s  = 1'($urandom_range(0, 1));
            w     = 1'($urandom_range(0, 1));
            n     = w ? 16 : 8;
            dvs_v = 16'($urandom);
            dvd_v = $urandom;
            if (i % 10 == 3) dvs_v = 16'h0000;
            dvs_m = longint'(dvs_v) & ((longint'(1) << n) - 1);
            // Most runs keep the high half below the divisor so results are valid.
            if (($urandom_range(0, 3) != 0) && dvs_m > 1) begin
                hi    = longint'($urandom) % (dvs_m / 2);
                dvd_v = 32'((hi << n) | (longint'($urandom) & ((longint'(1) << n) - 1)));
            end
            ref_div(op_s, w, dvd_v, dvs_v, eq, er, ee, lat);
            run_op($sformatf("rand%0d", i), op_s, w, dvd_v, dvs_v, eq, er, ee, lat, (i % 7 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
